// File: rtl/bcd_convert.sv
// Sequential binary-to-BCD converter (shift-add-3, one input bit per clock) with a
// valid/ready input handshake and a one-cycle result strobe. Optional: BCD_BLANK_EN.
module bcd_convert #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_r;
    logic [WIDTH-1:0]   bin_r;
    logic [BCD_W-1:0]   dig_r;
    logic               ovf_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [BCD_W-1:0]   adj_s;

    // Every digit >= 5 is corrected by +3 before the shift, all digits in parallel.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] d);
        logic [BCD_W-1:0] r;
        r = d;
        for (int i = 0; i < DIGITS; i++) begin
            if (d[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = d[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = d[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Saturates to all nines on overflow, then optionally blanks leading zeros (never digit 0).
    function automatic logic [BCD_W-1:0] finalize(input logic [BCD_W-1:0] d, input logic ovf);
        logic [BCD_W-1:0] r;
        r = ovf ? {DIGITS{4'd9}} : d;
`ifdef BCD_BLANK_EN
        begin
            logic lead;
            lead = 1'b1;
            for (int i = DIGITS - 1; i >= 1; i--) begin
                if (lead && (r[4*i +: 4] == 4'd0)) begin
                    r[4*i +: 4] = 4'hF;
                end else begin
                    lead = 1'b0;
                end
            end
        end
`endif
        return r;
    endfunction

    // Corrected scratch digits feeding the shift.
    assign adj_s = add3(dig_r);

    // Conversion FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            bin_r     <= '0;
            dig_r     <= '0;
            ovf_r     <= 1'b0;
            cnt_r     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_bcd   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        bin_r    <= in_data;
                        dig_r    <= '0;
                        ovf_r    <= 1'b0;
                        cnt_r    <= CNT_W'(WIDTH);
                        in_ready <= 1'b0;
                        state_r  <= SHIFT;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    // The bit leaving the top digit is sticky: any loss means overflow.
                    dig_r <= {adj_s[BCD_W-2:0], bin_r[WIDTH-1]};
                    bin_r <= bin_r << 1;
                    ovf_r <= ovf_r | adj_s[BCD_W-1];
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_r <= DONE;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                DONE: begin
                    out_bcd   <= finalize(dig_r, ovf_r);
                    out_ovf   <= ovf_r;
                    out_valid <= 1'b1;
                    in_ready  <= 1'b1;
                    state_r   <= IDLE;
                end
                default: begin
                    in_ready <= 1'b1;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_convert.sv
// Scoreboard bench for bcd_convert: directed vectors push expected results,
// per-instance monitors pop and compare on each out_valid strobe.
module tb_bcd_convert;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in2_valid;
    logic [7:0]  in_data, in2_data;
    logic        in_ready, out_valid, out_ovf;
    logic [11:0] out_bcd;
    logic        in2_ready, out2_valid, out2_ovf;
    logic [7:0]  out2_bcd;

    always #5 clk = ~clk;

    bcd_convert #(.WIDTH(8), .DIGITS(3)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_bcd(out_bcd), .out_ovf(out_ovf)
    );

    bcd_convert #(.WIDTH(8), .DIGITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in2_valid), .in_data(in2_data),
        .in_ready(in2_ready), .out_valid(out2_valid), .out_bcd(out2_bcd), .out_ovf(out2_ovf)
    );

    typedef struct packed {
        logic [11:0] bcd;
        logic        ovf;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    int   n_vec = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   low_cnt = 0;
    int   out1_cnt = 0;
    int   acc_cyc, acc_low;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] disp(input logic [11:0] v);
        logic [11:0] r;
        r = v;
`ifdef BCD_BLANK_EN
        if (r[11:8] == 4'd0) begin
            r[11:8] = 4'hF;
            if (r[7:4] == 4'd0) r[7:4] = 4'hF;
        end
`endif
        return r;
    endfunction

    function automatic logic [11:0] model(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (!in_ready) low_cnt <= low_cnt + 1;

    // Monitor for the 3-digit instance.
    always @(negedge clk) begin
        if (out_valid) begin
            out1_cnt <= out1_cnt + 1;
            if (q1.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got bcd %0h with no result expected", out_bcd);
            end else begin
                e1 = q1.pop_front();
                check("out_bcd", {20'd0, out_bcd}, {20'd0, e1.bcd});
                check("out_ovf", {31'd0, out_ovf}, {31'd0, e1.ovf});
            end
        end
    end

    // Monitor for the 2-digit instance.
    always @(negedge clk) begin
        if (out2_valid) begin
            if (q2.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_out2_valid: got bcd %0h with no result expected", out2_bcd);
            end else begin
                e2 = q2.pop_front();
                check("out2_bcd", {24'd0, out2_bcd}, {24'd0, e2.bcd[7:0]});
                check("out2_ovf", {31'd0, out2_ovf}, {31'd0, e2.ovf});
            end
        end
    end

    // Waits (bounded) for ready, registers the expectation, returns just after the accept edge.
    task automatic send(input bit sel, input logic [7:0] d, input logic [11:0] eb,
                        input logic eo, input bit push);
        exp_t e;
        e.bcd = sel ? eb : disp(eb);
        e.ovf = eo;
        if (sel) begin
            in2_data = d; in2_valid = 1'b1;
        end else begin
            in_data = d; in_valid = 1'b1;
        end
        for (int i = 0; i < 40; i++) begin
            if (sel ? in2_ready : in_ready) break;
            @(negedge clk);
        end
        if (!(sel ? in2_ready : in_ready)) begin
            n_vec++;
            n_fail++;
            $display("FAIL send_timeout: in_ready still 0 for data %0d", d);
        end else if (push) begin
            if (sel) q2.push_back(e);
            else     q1.push_back(e);
        end
        acc_cyc = cyc;
        acc_low = low_cnt;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (q1.size() == 0 && q2.size() == 0) break;
            @(negedge clk);
        end
        check("drain_q1_empty", q1.size(), 0);
        check("drain_q2_empty", q2.size(), 0);
    endtask

    logic [7:0]  dv[5];
    logic [11:0] de[5];
    int          lat, prev_cyc, prev_low, cnt_before;

    initial begin
        dv = '{8'd0, 8'd99, 8'd100, 8'd7, 8'd105};
        de = '{12'h000, 12'h099, 12'h100, 12'h007, 12'h105};
        rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; in2_valid = 1'b0; in2_data = 8'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_bcd", {20'd0, out_bcd}, 32'd0);
        check("reset_out_ovf", {31'd0, out_ovf}, 32'd0);

        // 255 with latency measurement
        send(1'b0, 8'd255, 12'h255, 1'b0, 1'b1);
        in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        check("latency_edges", lat, 9);
        repeat (5) @(negedge clk);
        check("hold_out_bcd", {20'd0, out_bcd}, {20'd0, disp(12'h255)});
        check("hold_out_valid", {31'd0, out_valid}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            send(1'b0, dv[i], de[i], 1'b0, 1'b1);
            in_valid = 1'b0;
        end
        drain();

        // Back-to-back sweep with in_valid held high
        prev_cyc = 0; prev_low = 0;
        for (int v = 0; v < 256; v++) begin
            send(1'b0, 8'(v), model(v), 1'b0, 1'b1);
            if (v > 0) begin
                check("accept_interval", acc_cyc - prev_cyc, 10);
                check("ready_low_cycles", acc_low - prev_low, 9);
            end
            prev_cyc = acc_cyc;
            prev_low = acc_low;
        end
        in_valid = 1'b0;
        drain();

        // Reset during a conversion discards it
        send(1'b0, 8'd200, 12'h200, 1'b0, 1'b0);
        in_valid = 1'b0;
        cnt_before = out1_cnt;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_mid_out_bcd", {20'd0, out_bcd}, 32'd0);
        check("rst_mid_out_ovf", {31'd0, out_ovf}, 32'd0);
        repeat (15) @(negedge clk);
        check("rst_mid_no_strobe", out1_cnt, cnt_before);

        // Two-digit instance: overflow saturation
        send(1'b1, 8'd255, 12'h099, 1'b1, 1'b1);
        send(1'b1, 8'd42,  12'h042, 1'b0, 1'b1);
        send(1'b1, 8'd100, 12'h099, 1'b1, 1'b1);
        send(1'b1, 8'd99,  12'h099, 1'b0, 1'b1);
        in2_valid = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
